// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - datapath control bundle between multicycle controller and datapath
interface multicycle_controller_if #(
   parameter int ALU_CTRL_W = 5
);
   logic [5:0]            opcode;
   logic                  mem_ready;
   logic                  zero;
   logic                  pc_write;
   logic                  IorD;
   logic                  IRWrite;
   logic                  RegDst;
   logic                  RegWrite;
   logic                  ALUsrcA;
   logic                  MemWrite;
   logic                  MemRead;
   logic                  MemToReg;
   logic                  illegal;
   logic [1:0]            pc_src;
   logic [1:0]            ALUsrcB;
   logic [ALU_CTRL_W-1:0] alu_control;
   logic [3:0]            state;

   modport master (
      input  opcode, mem_ready, zero,
      output pc_write, IorD, IRWrite, RegDst, RegWrite, ALUsrcA, MemWrite, MemRead,
             MemToReg, illegal, pc_src, ALUsrcB, alu_control, state
   );

   modport slave (
      output opcode, mem_ready, zero,
      input  pc_write, IorD, IRWrite, RegDst, RegWrite, ALUsrcA, MemWrite, MemRead,
             MemToReg, illegal, pc_src, ALUsrcB, alu_control, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle Moore control FSM for a MIPS-style datapath
module multicycle_controller #(
   parameter int ALU_CTRL_W  = 5,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   multicycle_controller_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b101);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);

   state_t     state_q;
   logic [5:0] op_q;
   logic       ready;

   assign ready     = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
   assign bus.state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= 6'h00;
      end else begin
         case (state_q)
            S_FETCH:    if (ready) state_q <= S_DECODE;
            S_DECODE: begin
               op_q <= bus.opcode;
               case (bus.opcode)
                  6'h00:        state_q <= S_EXEC_R;
                  6'h08:        state_q <= S_EXEC_I;
                  6'h23, 6'h2b: state_q <= S_MEM_ADDR;
                  6'h04:        state_q <= S_BRANCH;
                  6'h02:        state_q <= S_JUMP;
                  default:      state_q <= S_ILLEGAL;
               endcase
            end
            S_MEM_ADDR: state_q <= (op_q == 6'h2b) ? S_MEM_WR :
                                   (op_q == 6'h23) ? S_MEM_RD : S_ILLEGAL;
            S_MEM_RD:   if (ready) state_q <= S_MEM_WB;
            S_MEM_WR:   if (ready) state_q <= S_FETCH;
            S_EXEC_R:   state_q <= S_R_WB;
            S_EXEC_I:   state_q <= S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                        state_q <= S_FETCH;
            S_ILLEGAL:  state_q <= S_ILLEGAL;
            default:    state_q <= S_ILLEGAL;
         endcase
      end
   end

   // FETCH write enables follow mem_ready combinationally, so rst_n gates them to keep reset silent
   always_comb begin
      bus.pc_write    = 1'b0;
      bus.IorD        = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUsrcA     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemToReg    = 1'b0;
      bus.illegal     = 1'b0;
      bus.pc_src      = 2'b00;
      bus.ALUsrcB     = 2'b00;
      bus.alu_control = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            bus.MemRead  = 1'b1;
            bus.ALUsrcB  = 2'b01;
            bus.IRWrite  = ready & rst_n;
            bus.pc_write = ready & rst_n;
         end
         S_DECODE:   bus.ALUsrcB = 2'b11;
         S_MEM_ADDR, S_EXEC_I: begin
            bus.ALUsrcA = 1'b1;
            bus.ALUsrcB = 2'b10;
         end
         S_MEM_RD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEM_WB: begin
            bus.RegWrite = 1'b1;
            bus.MemToReg = 1'b1;
         end
         S_MEM_WR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
         end
         S_EXEC_R:   bus.ALUsrcA = 1'b1;
         S_R_WB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_I_WB:     bus.RegWrite = 1'b1;
         S_BRANCH: begin
            bus.ALUsrcA     = 1'b1;
            bus.alu_control = ALU_SUB;
            bus.pc_src      = 2'b01;
            bus.pc_write    = bus.zero;
         end
         S_JUMP: begin
            bus.pc_src   = 2'b10;
            bus.pc_write = 1'b1;
         end
         S_ILLEGAL:  bus.illegal = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   multicycle_controller_if #(.ALU_CTRL_W(5)) b ();
   multicycle_controller_if #(.ALU_CTRL_W(5)) b2 ();

   multicycle_controller #(.ALU_CTRL_W(5), .MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b));
   multicycle_controller #(.ALU_CTRL_W(5), .MEM_WAIT_EN(1'b0)) dut_nowait (
      .clk(clk), .rst_n(rst_n), .bus(b2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected control word for a state, straight from the state/output table
   function automatic logic [18:0] exp_ctl(int st, bit mr, bit z);
      bit pw, iord, irw, rd, rw, sa, mw, mrd, m2r, ill;
      bit [1:0] ps, sb;
      bit [4:0] alu;
      {pw, iord, irw, rd, rw, sa, mw, mrd, m2r, ill} = '0;
      ps = 2'b00; sb = 2'b00; alu = 5'd5;
      case (st)
         0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  sa = 1;
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; sb = 2'b10; end
         9:  rw = 1;
         10: begin sa = 1; alu = 5'd6; ps = 2'b01; pw = z; end
         11: begin ps = 2'b10; pw = 1; end
         12: ill = 1;
         default: ;
      endcase
      return {pw, iord, irw, rd, rw, sa, mw, mrd, m2r, ill, ps, sb, alu};
   endfunction

   function automatic logic [18:0] act_ctl();
      return {b.pc_write, b.IorD, b.IRWrite, b.RegDst, b.RegWrite, b.ALUsrcA, b.MemWrite,
              b.MemRead, b.MemToReg, b.illegal, b.pc_src, b.ALUsrcB, b.alu_control};
   endfunction

   task automatic do_reset();
      b.mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_state", 32'(b.state), 32'd0);
      check("rst_we_ill", 32'({b.pc_write, b.IRWrite, b.RegWrite, b.MemWrite, b.illegal}), 32'd0);
      @(posedge clk); #1;
      check("rst_hold_we", 32'({b.pc_write, b.IRWrite, b.RegWrite, b.MemWrite, b.illegal, b.state}), 32'd0);
      rst_n = 1'b1;
   endtask

   // Builds the expected per-cycle state trace of one instruction, then drives and compares it
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z, input int abort);
      int st[$];
      bit mr[$];
      for (int k = 0; k < fw; k++) begin st.push_back(0); mr.push_back(1'b0); end
      st.push_back(0); mr.push_back(1'b1);
      st.push_back(1); mr.push_back(1'($urandom));
      case (op)
         6'h00: begin st.push_back(6); st.push_back(7); end
         6'h08: begin st.push_back(8); st.push_back(9); end
         6'h04: st.push_back(10);
         6'h02: st.push_back(11);
         6'h23, 6'h2b: st.push_back(2);
         default: for (int k = 0; k < 4; k++) st.push_back(12);
      endcase
      while (mr.size() < st.size()) mr.push_back(1'($urandom));
      if (op == 6'h23 || op == 6'h2b) begin
         for (int k = 0; k < mw; k++) begin st.push_back(op == 6'h23 ? 3 : 5); mr.push_back(1'b0); end
         st.push_back(op == 6'h23 ? 3 : 5); mr.push_back(1'b1);
         if (op == 6'h23) begin st.push_back(4); mr.push_back(1'($urandom)); end
      end
      for (int i = 0; i < st.size(); i++) begin
         b.opcode    = (i <= fw + 1) ? op : 6'($urandom);
         b.mem_ready = mr[i];
         b.zero      = z;
         #1;
         check($sformatf("op%0h_c%0d_state", op, i), 32'(b.state), 32'(st[i]));
         check($sformatf("op%0h_c%0d_ctl", op, i), 32'(act_ctl()), 32'(exp_ctl(st[i], mr[i], z)));
         if (i == abort) begin
            do_reset();
            return;
         end
         @(posedge clk); #1;
      end
      if (st[st.size()-1] == 12) do_reset();
   endtask

   initial begin
      logic [5:0] ops [6];
      ops = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02};
      b.opcode = 6'h00; b.mem_ready = 1'b1; b.zero = 1'b0;
      b2.opcode = 6'h2b; b2.mem_ready = 1'b0; b2.zero = 1'b0;
      #2;
      check("reset_state", 32'(b.state), 32'd0);
      check("reset_we", 32'({b.pc_write, b.IRWrite, b.RegWrite, b.MemWrite, b.illegal}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_instr(6'h00, 0, 0, 1'b0, -1);
      run_instr(6'h23, 0, 2, 1'b0, -1);
      run_instr(6'h04, 0, 0, 1'b1, -1);
      run_instr(6'h04, 1, 0, 1'b0, -1);
      run_instr(6'h2b, 0, 3, 1'b0, 4);
      run_instr(6'h08, 2, 0, 1'b1, -1);
      run_instr(6'h02, 1, 0, 1'b0, -1);
      for (int n = 0; n < 40; n++) begin
         run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   1'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1);
      end
      run_instr(6'h3f, 0, 0, 1'b0, -1);
      run_instr(6'h15, 1, 0, 1'b1, -1);

      // Controller built without wait support must finish SW in 4 cycles with mem_ready stuck low
      do_reset();
      begin
         int exp_st [5];
         exp_st = '{0, 1, 2, 5, 0};
         for (int i = 0; i < 5; i++) begin
            b2.opcode = 6'h2b; b2.mem_ready = 1'b0;
            #1;
            check($sformatf("nowait_c%0d_state", i), 32'(b2.state), 32'(exp_st[i]));
            check($sformatf("nowait_c%0d_ctl", i), 32'({b2.pc_write, b2.IorD, b2.IRWrite, b2.RegDst,
                  b2.RegWrite, b2.ALUsrcA, b2.MemWrite, b2.MemRead, b2.MemToReg, b2.illegal,
                  b2.pc_src, b2.ALUsrcB, b2.alu_control}), 32'(exp_ctl(exp_st[i], 1'b1, 1'b0)));
            @(posedge clk); #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 5, width of alu_control (>=3); 3-bit ALU codes zero-extended.
REQ-002 SHALL have parameter MEM_WAIT_EN, default 1; when 0, mem_ready is ignored and treated as 1.
REQ-003 SHALL have port clk  input  1  single clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port opcode  input  6  instruction opcode from instruction register.
REQ-006 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have outputs pc_write, IorD, IRWrite, RegDst, RegWrite, ALUsrcA, MemWrite, MemRead, MemToReg, illegal, each 1 bit.
REQ-009 SHALL have outputs pc_src[1:0] (00 ALU, 01 ALUOut, 10 jump target), ALUsrcB[1:0] (00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm), alu_control[ALU_CTRL_W-1:0], state[3:0].

Function
REQ-010 SHALL be a multi-cycle Moore FSM; state output equals current encoding; outputs decoded from state only, except the mem_ready/zero gating stated below.
REQ-011 SHALL default every unlisted output to 0 and alu_control to add (3'b101) in every state.
REQ-012 FETCH(0): MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, add; IRWrite=pc_write=mem_ready, pc_src=00; stay while !mem_ready, else DECODE.
REQ-013 DECODE(1): ALUsrcA=0, ALUsrcB=11, add; SHALL latch opcode into internal op_q; next by opcode: 6'h0 EXEC_R, 6'h8 EXEC_I, 6'h23/6'h2b MEM_ADDR, 6'h4 BRANCH, 6'h2 JUMP, other ILLEGAL.
REQ-014 States after DECODE SHALL use op_q only; opcode changes after DECODE have no effect.
REQ-015 MEM_ADDR(2): ALUsrcA=1, ALUsrcB=10, add; op_q 6'h23 -> MEM_RD, 6'h2b -> MEM_WR.
REQ-016 MEM_RD(3): MemRead=1, IorD=1; stay while !mem_ready, else MEM_WB.
REQ-017 MEM_WB(4): RegDst=0, RegWrite=1, MemToReg=1; -> FETCH.
REQ-018 MEM_WR(5): MemWrite=1, IorD=1; stay while !mem_ready (MemWrite held), else FETCH.
REQ-019 EXEC_R(6): ALUsrcA=1, ALUsrcB=00, add; -> R_WB(7): RegDst=1, RegWrite=1; -> FETCH.
REQ-020 EXEC_I(8): ALUsrcA=1, ALUsrcB=10, add; -> I_WB(9): RegDst=0, RegWrite=1; -> FETCH.
REQ-021 BRANCH(10): ALUsrcA=1, ALUsrcB=00, alu_control=sub (3'b110), pc_src=01, pc_write=zero; -> FETCH.
REQ-022 JUMP(11): pc_src=10, pc_write=1; -> FETCH.
REQ-023 ILLEGAL(12): illegal=1, all write enables 0; SHALL remain until reset.
REQ-024 Encodings 13-15 SHALL transition to ILLEGAL next cycle.
REQ-025 Zero-wait latency in cycles: R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3; each mem_ready-low cycle in FETCH/MEM_RD/MEM_WR adds one.
REQ-026 At most one of RegWrite, MemWrite SHALL be 1 in any cycle; IRWrite only in FETCH.

Reset
REQ-027 rst_n low SHALL immediately force state=FETCH, op_q=0, illegal=0, and all write enables (pc_write, IRWrite, RegWrite, MemWrite) to 0, regardless of clk.
REQ-028 First rising clk edge after rst_n rises SHALL evaluate FETCH normally.
REQ-029 Reset mid-instruction (any state, incl. wait states) SHALL abandon the instruction with no further write-enable pulse.

Verification
REQ-030 Reset, opcode=6'h0, mem_ready=1 -> states 0,1,6,7,0; RegDst=RegWrite=1 only in cycle 4; alu_control=5.
REQ-031 opcode=6'h23, mem_ready low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; MemToReg=RegWrite=1 in state 4 only.
REQ-032 opcode=6'h4, zero=1 then zero=0 on repeat -> pc_write=1 with pc_src=01 in BRANCH first time, pc_write=0 second; alu_control=6.
REQ-033 opcode=6'h3f -> states 0,1,12,12...; illegal=1 held; no write enable asserted; rst_n low returns to state 0, illegal=0.
REQ-034 opcode=6'h2b, rst_n pulsed low during MEM_WR -> MemWrite drops asynchronously, state=0; MEM_WAIT_EN=0 build with mem_ready=0 -> SW completes in 4 cycles.
